encoder_8b10b_tx_sched: RTL and testbench
=========================================

# encoder_8b10b_tx_sched

Transmit-side sequencer for the 8B/10B link. Accepts a byte stream over a valid/ready handshake and drives one `encoder_8b10b_1byte` instance every clock. It owns the running-disparity register, runs the link start-up comma training, fills gaps with idle commas, and periodically inserts alignment comma bursts. The registered 10-bit output feeds the serializer directly at one symbol per clock.

## Interface
- `TRAIN_LEN`, 64: number of K28.5 symbols sent in TRAIN before data is accepted (≥1).
- `ALIGN_PERIOD`, 1024: RUN cycles between alignment bursts (≥2).
- `ALIGN_BURST`, 2: K28.5 symbols per alignment burst (≥1).
- `i_clk` in 1: symbol clock; all logic uses only this clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_enable` in 1: link enable.
- `i_data` in 8: payload byte.
- `i_datak` in 1: 1 = `i_data` is a K character.
- `i_valid` in 1: payload valid.
- `o_ready` out 1: a byte is accepted on any edge where `i_valid && o_ready`.
- `o_data10` out 10: registered encoded symbol, bit 0 = a, bit 9 = j.
- `o_run_disp` out 1: registered running disparity after the current `o_data10` (0 = RD−).
- `o_train_done` out 1: high in RUN and ALIGN.
- `o_align_active` out 1: high in ALIGN.
- `o_kerr` out 1: one-cycle pulse for an illegal K byte (see Configuration).

## Operation
- FSM states: OFF, TRAIN, RUN, ALIGN. Reset enters OFF.
- OFF:
  - Emits K28.5; `o_ready` = 0.
  - `i_enable` = 1 → TRAIN, with the train counter cleared.
- TRAIN:
  - Emits K28.5 for `TRAIN_LEN` cycles, then → RUN, with the align counter cleared.
- RUN:
  - `o_ready` = 1.
  - If `i_valid` = 1, the encoder is fed `i_data`/`i_datak`. Otherwise it is fed K28.5 (0xBC, k = 1) as idle.
  - The align counter increments every RUN cycle. On the cycle it reaches `ALIGN_PERIOD`−1, that cycle still transfers normally; the next state is ALIGN.
- ALIGN:
  - Emits K28.5 for `ALIGN_BURST` cycles with `o_ready` = 0, then → RUN with the align counter cleared.
- `i_enable` = 0 in any state: next state is OFF and all counters clear.
- `o_ready` is combinational: `(state == RUN) && i_enable`. A byte is never accepted in the cycle `i_enable` is low.
- Running-disparity register:
  - Drives the encoder's `i_run_disp`.
  - Loads the encoder's `o_run_disp` every cycle, in every state, so idle and comma symbols keep disparity correct.
- Counter widths: `$clog2` of the respective parameter, minimum 1 bit. Counters never wrap in normal operation.
- K28.5 idles alternate between 0x17C (sent at RD−) and 0x283 (sent at RD+).

## Timing
- Reset values:
  - `o_data10` = 10'h283 (K28.5 RD+ form, which leaves RD−).
  - `o_run_disp` = 0; `o_ready` = 0; `o_train_done` = 0; `o_align_active` = 0; `o_kerr` = 0.
  - State = OFF.
- Latency: a byte accepted at edge N appears on `o_data10` after edge N, i.e. one cycle. `o_run_disp` updates on the same edge.
- The first accept is possible `TRAIN_LEN`+1 edges after `i_enable` is first sampled high.
- `i_rst` asserted mid-burst or mid-transfer: on the next edge all outputs take their reset values and the in-flight byte is dropped.
- Simultaneous events:
  - `i_enable` falling on the align-terminal cycle: OFF wins.
  - `i_valid` with `o_ready` = 0: nothing is consumed and upstream holds its data.

## Configuration
- `ENC8B10B_SCHED_KCHECK_EN` defined:
  - A byte accepted with `i_datak` = 1 is checked against the legal K set {0x1C, 0x3C, 0x5C, 0x7C, 0x9C, 0xBC, 0xDC, 0xFC, 0xF7, 0xFB, 0xFD, 0xFE}.
  - An illegal byte is encoded as K28.5 instead, and `o_kerr` pulses high for one cycle aligned with that symbol on `o_data10`.
- Not defined:
  - K bytes pass to the encoder unchanged.
  - `o_kerr` is tied to 0.

## Test plan
- Reset and enable:
  - Assert `i_rst` for 2 cycles, then hold `i_enable` = 0 → `o_data10` = 0x283, `o_run_disp` = 0, `o_ready` = 0.
  - Raise `i_enable` with `TRAIN_LEN` = 4 → output sequence 0x17C, 0x283, 0x17C, 0x283, then `o_ready` and `o_train_done` high.
- Data in RUN:
  - Send 0xB5 with k = 0 (D21.5) → next-cycle `o_data10` = 0x155, `o_run_disp` unchanged.
  - Send 0x00 with k = 0 at RD− → `o_data10` = 0x0B9, `o_run_disp` = 0.
- Alignment with `ALIGN_PERIOD` = 8, `ALIGN_BURST` = 2 and continuous `i_valid`:
  - Exactly 8 bytes accepted, then `o_ready` low for 2 cycles with `o_align_active` high and two K28.5 symbols, then accepts resume.
  - The byte order out matches the byte order in.
- Disable mid-stream: drop `i_enable` during RUN with `i_valid` high → no accept that cycle, state is OFF next edge, and re-enable repeats full TRAIN.
- K check, with the macro defined: send 0xAB with k = 1 → the output is K28.5 for the current RD and `o_kerr` is a one-cycle pulse. Without the macro, `o_kerr` stays 0.

Source files
------------

// File: rtl/encoder_8b10b_tx_sched.sv
// 8B/10B transmit sequencer: comma training, idle fill, periodic alignment bursts.
// Define ENC8B10B_SCHED_KCHECK_EN to replace illegal K bytes with K28.5 and pulse o_kerr.
module encoder_8b10b_1byte (
    input  logic [7:0] i_data,
    input  logic       i_datak,
    input  logic       i_run_disp,
    output logic [9:0] o_data10,
    output logic       o_run_disp
);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6_neg, c6;
    logic [3:0] c4_neg, c4;
    logic       k28, unbal6, unbal4, rd_mid, use_a7;

    always_comb begin
        x = i_data[4:0];
        y = i_data[7:5];
        k28 = i_datak && (x == 5'd28);
        // 5b/6b codes in abcdei order (MSB = a), RD- column
        case (x)
            5'd0:  c6_neg = 6'b100111;  5'd1:  c6_neg = 6'b011101;
            5'd2:  c6_neg = 6'b101101;  5'd3:  c6_neg = 6'b110001;
            5'd4:  c6_neg = 6'b110101;  5'd5:  c6_neg = 6'b101001;
            5'd6:  c6_neg = 6'b011001;  5'd7:  c6_neg = 6'b111000;
            5'd8:  c6_neg = 6'b111001;  5'd9:  c6_neg = 6'b100101;
            5'd10: c6_neg = 6'b010101;  5'd11: c6_neg = 6'b110100;
            5'd12: c6_neg = 6'b001101;  5'd13: c6_neg = 6'b101100;
            5'd14: c6_neg = 6'b011100;  5'd15: c6_neg = 6'b010111;
            5'd16: c6_neg = 6'b011011;  5'd17: c6_neg = 6'b100011;
            5'd18: c6_neg = 6'b010011;  5'd19: c6_neg = 6'b110010;
            5'd20: c6_neg = 6'b001011;  5'd21: c6_neg = 6'b101010;
            5'd22: c6_neg = 6'b011010;  5'd23: c6_neg = 6'b111010;
            5'd24: c6_neg = 6'b110011;  5'd25: c6_neg = 6'b100110;
            5'd26: c6_neg = 6'b010110;  5'd27: c6_neg = 6'b110110;
            5'd28: c6_neg = k28 ? 6'b001111 : 6'b001110;
            5'd29: c6_neg = 6'b101110;  5'd30: c6_neg = 6'b011110;
            default: c6_neg = 6'b101011;
        endcase
        unbal6 = ($countones(c6_neg) != 3);
        c6     = (i_run_disp && (unbal6 || x == 5'd7)) ? ~c6_neg : c6_neg;
        rd_mid = i_run_disp ^ unbal6;

        // Alternate x.7 avoids a run of five equal bits across the sub-block boundary
        use_a7 = (y == 3'd7) && (i_datak ||
                 (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                 ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        case (y)
            3'd0: c4_neg = 4'b1011;
            3'd1: c4_neg = 4'b1001;
            3'd2: c4_neg = 4'b0101;
            3'd3: c4_neg = 4'b1100;
            3'd4: c4_neg = 4'b1101;
            3'd5: c4_neg = 4'b1010;
            3'd6: c4_neg = 4'b0110;
            default: c4_neg = use_a7 ? 4'b0111 : 4'b1110;
        endcase
        unbal4 = ($countones(c4_neg) != 2);
        if (k28 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6))
            c4 = rd_mid ? c4_neg : ~c4_neg;
        else
            c4 = (rd_mid && (unbal4 || y == 3'd3)) ? ~c4_neg : c4_neg;
        o_run_disp = rd_mid ^ unbal4;

        o_data10 = '0;
        for (int i = 0; i < 6; i++) o_data10[i] = c6[5 - i];
        for (int i = 0; i < 4; i++) o_data10[6 + i] = c4[3 - i];
    end
endmodule

module encoder_8b10b_tx_sched #(
    parameter int TRAIN_LEN    = 64,
    parameter int ALIGN_PERIOD = 1024,
    parameter int ALIGN_BURST  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic [7:0] i_data,
    input  logic       i_datak,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [9:0] o_data10,
    output logic       o_run_disp,
    output logic       o_train_done,
    output logic       o_align_active,
    output logic       o_kerr,
    output logic [1:0] o_state
);
    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam int AW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
    localparam int BW = (ALIGN_BURST > 1) ? $clog2(ALIGN_BURST) : 1;
    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_PERIOD - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(ALIGN_BURST - 1);
    localparam logic [7:0]    K28_5      = 8'hBC;

    typedef enum logic [1:0] {ST_OFF, ST_TRAIN, ST_RUN, ST_ALIGN} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   train_cnt, train_n;
    logic [AW-1:0]   align_cnt, align_n;
    logic [BW-1:0]   burst_cnt, burst_n;
    logic            run_disp;
    logic [7:0]      enc_data;
    logic            enc_k;
    logic [9:0]      enc_sym;
    logic            enc_rd;
    logic            accept;

    assign o_ready        = (state == ST_RUN) && i_enable;
    assign accept         = o_ready && i_valid;
    assign o_train_done   = (state == ST_RUN) || (state == ST_ALIGN);
    assign o_align_active = (state == ST_ALIGN);
    assign o_run_disp     = run_disp;
    assign o_state        = state;

`ifdef ENC8B10B_SCHED_KCHECK_EN
    logic kerr_n, kerr_q;
    logic k_legal;
    always_comb begin
        case (i_data)
            8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
            8'hF7, 8'hFB, 8'hFD, 8'hFE: k_legal = 1'b1;
            default:                    k_legal = 1'b0;
        endcase
    end
    assign o_kerr = kerr_q;
`else
    assign o_kerr = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        train_n  = train_cnt;
        align_n  = align_cnt;
        burst_n  = burst_cnt;
        enc_data = K28_5;
        enc_k    = 1'b1;
`ifdef ENC8B10B_SCHED_KCHECK_EN
        kerr_n   = 1'b0;
`endif
        case (state)
            ST_OFF: begin
                if (i_enable) begin
                    state_n = ST_TRAIN;
                    train_n = '0;
                end
            end
            ST_TRAIN: begin
                if (train_cnt == TRAIN_LAST) begin
                    state_n = ST_RUN;
                    align_n = '0;
                end else begin
                    train_n = train_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    enc_data = i_data;
                    enc_k    = i_datak;
`ifdef ENC8B10B_SCHED_KCHECK_EN
                    if (i_datak && !k_legal) begin
                        enc_data = K28_5;
                        kerr_n   = 1'b1;
                    end
`endif
                end
                // The terminal cycle still transfers; the burst follows it
                if (align_cnt == ALIGN_LAST) begin
                    state_n = ST_ALIGN;
                    burst_n = '0;
                end else begin
                    align_n = align_cnt + 1'b1;
                end
            end
            ST_ALIGN: begin
                if (burst_cnt == BURST_LAST) begin
                    state_n = ST_RUN;
                    align_n = '0;
                end else begin
                    burst_n = burst_cnt + 1'b1;
                end
            end
            default: state_n = ST_OFF;
        endcase
        if (!i_enable) begin
            state_n = ST_OFF;
            train_n = '0;
            align_n = '0;
            burst_n = '0;
        end
    end

    encoder_8b10b_1byte u_enc (
        .i_data     (enc_data),
        .i_datak    (enc_k),
        .i_run_disp (run_disp),
        .o_data10   (enc_sym),
        .o_run_disp (enc_rd)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_OFF;
            train_cnt <= '0;
            align_cnt <= '0;
            burst_cnt <= '0;
            o_data10  <= 10'h283;
            run_disp  <= 1'b0;
`ifdef ENC8B10B_SCHED_KCHECK_EN
            kerr_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            train_cnt <= train_n;
            align_cnt <= align_n;
            burst_cnt <= burst_n;
            o_data10  <= enc_sym;
            run_disp  <= enc_rd;
`ifdef ENC8B10B_SCHED_KCHECK_EN
            kerr_q    <= kerr_n;
`endif
        end
    end
endmodule

// File: tb/tb_encoder_8b10b_tx_sched.sv
// Self-checking bench for encoder_8b10b_tx_sched: expected symbols queued as stimulus is driven.
module tb_encoder_8b10b_tx_sched;
    localparam int TL = 4;
    localparam int AP = 8;
    localparam int AB = 2;
    localparam logic [9:0] IDLE_TOK = {1'b0, 1'b1, 8'hBC};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] data = 8'h00;
    logic       datak = 1'b0;
    logic       valid = 1'b0;
    logic       ready;
    logic [9:0] data10;
    logic       run_disp;
    logic       train_done;
    logic       align_active;
    logic       kerr;
    logic [1:0] state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    // token = {kerr expected, k, byte} of the symbol the DUT should emit
    logic [9:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic       model_rd = 1'b0;
    int         run_cnt = 0;
    int         align_left = 0;

    encoder_8b10b_tx_sched #(
        .TRAIN_LEN    (TL),
        .ALIGN_PERIOD (AP),
        .ALIGN_BURST  (AB)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_data         (data),
        .i_datak        (datak),
        .i_valid        (valid),
        .o_ready        (ready),
        .o_data10       (data10),
        .o_run_disp     (run_disp),
        .o_train_done   (train_done),
        .o_align_active (align_active),
        .o_kerr         (kerr),
        .o_state        (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference symbols from the standard 8B/10B tables (bit 0 = a)
    function automatic logic [9:0] ref_code(input logic [8:0] kd, input logic rd);
        case (kd)
            9'h1BC:  ref_code = rd ? 10'h283 : 10'h17C;
            9'h0B5:  ref_code = 10'h155;
            9'h000:  ref_code = rd ? 10'h346 : 10'h0B9;
            9'h04A:  ref_code = 10'h2AA;
            9'h0FF:  ref_code = rd ? 10'h1CA : 10'h235;
            9'h1AB:  ref_code = 10'h14B;
            default: ref_code = 10'h000;
        endcase
    endfunction

    function automatic logic [8:0] pick_byte(input int idx);
        case (idx)
            0:       pick_byte = 9'h0B5;
            1:       pick_byte = 9'h000;
            2:       pick_byte = 9'h04A;
            3:       pick_byte = 9'h0FF;
            default: pick_byte = 9'h1BC;
        endcase
    endfunction

    function automatic logic [9:0] token_for(input logic v, input logic [7:0] d, input logic k);
        logic legal;
        legal = (d == 8'h1C) || (d == 8'h3C) || (d == 8'h5C) || (d == 8'h7C) ||
                (d == 8'h9C) || (d == 8'hBC) || (d == 8'hDC) || (d == 8'hFC) ||
                (d == 8'hF7) || (d == 8'hFB) || (d == 8'hFD) || (d == 8'hFE);
        if (!v) return IDLE_TOK;
`ifdef ENC8B10B_SCHED_KCHECK_EN
        if (k && !legal) return {1'b1, 1'b1, 8'hBC};
`else
        legal = 1'b1;
`endif
        return {1'b0, k, d};
    endfunction

    task automatic monitor_loop();
        logic [9:0] tok;
        logic [9:0] code;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL sb_underflow: got symbol %h with no expectation queued", data10);
                end else begin
                    tok  = exp_q.pop_front();
                    code = ref_code(tok[8:0], model_rd);
                    if ($countones(code) != 5) model_rd = ~model_rd;
                    tests_run++;
                    if (data10 !== code) begin
                        tests_failed++;
                        $display("FAIL sb_symbol: got %h required %h (byte %h k %b)", data10, code, tok[7:0], tok[8]);
                    end
                    tests_run++;
                    if (run_disp !== model_rd) begin
                        tests_failed++;
                        $display("FAIL sb_run_disp: got %b required %b", run_disp, model_rd);
                    end
                    tests_run++;
                    if (kerr !== tok[9]) begin
                        tests_failed++;
                        $display("FAIL sb_kerr: got %b required %b", kerr, tok[9]);
                    end
                end
            end
        end
    endtask

    // One RUN/ALIGN cycle: drive at the falling edge, queue the expected symbol
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic k,
                               output logic exp_ready, output logic exp_align);
        @(negedge clk);
        valid = v;
        data  = d;
        datak = k;
        if (align_left == 0) begin
            exp_ready = 1'b1;
            exp_align = 1'b0;
            exp_q.push_back(token_for(v, d, k));
            if (run_cnt == AP - 1) begin
                run_cnt    = 0;
                align_left = AB;
            end else begin
                run_cnt++;
            end
        end else begin
            exp_ready = 1'b0;
            exp_align = 1'b1;
            exp_q.push_back(IDLE_TOK);
            align_left--;
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; valid = 1'b0; data = 8'h00; datak = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (data10 !== 10'h283) begin tests_failed++; $display("FAIL reset_data10: got %h required 283", data10); end
        tests_run++;
        if (run_disp !== 1'b0) begin tests_failed++; $display("FAIL reset_run_disp: got %b required 0", run_disp); end
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b required 0", ready); end
        tests_run++;
        if (train_done !== 1'b0 || align_active !== 1'b0 || kerr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got train_done %b align %b kerr %b required 000", train_done, align_active, kerr);
        end
        tests_run++;
        if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
        model_rd = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        exp_q.push_back(IDLE_TOK);
    endtask

    task automatic test_train();
        @(negedge clk);
        enable = 1'b1;
        exp_q.push_back(IDLE_TOK);
        #1;
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("FAIL off_ready: got %b required 0", ready); end
        for (int i = 0; i < TL; i++) begin
            @(negedge clk);
            exp_q.push_back(IDLE_TOK);
            #1;
            tests_run++;
            if (ready !== 1'b0 || train_done !== 1'b0 || state_dbg !== 2'd1) begin
                tests_failed++;
                $display("FAIL train_cycle%0d: got ready %b done %b state %0d required 0 0 1", i, ready, train_done, state_dbg);
            end
        end
        run_cnt = 0;
        align_left = 0;
    endtask

    task automatic test_data();
        logic er, ea;
        drive_cycle(1'b1, 8'hB5, 1'b0, er, ea);
        tests_run++;
        if (ready !== 1'b1 || train_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL run_entry: got ready %b done %b required 1 1", ready, train_done);
        end
        drive_cycle(1'b1, 8'h00, 1'b0, er, ea);
        tests_run++;
        if (data10 !== 10'h155 || run_disp !== 1'b0) begin
            tests_failed++;
            $display("FAIL d21_5: got %h rd %b required 155 rd 0", data10, run_disp);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, er, ea);
        tests_run++;
        if (data10 !== 10'h0B9 || run_disp !== 1'b0) begin
            tests_failed++;
            $display("FAIL d0_0: got %h rd %b required 0B9 rd 0", data10, run_disp);
        end
    endtask

    task automatic test_align();
        logic       er, ea;
        logic [8:0] cur;
        int         streak;
        int         low_len;
        streak  = -1;
        low_len = 0;
        cur     = pick_byte($urandom_range(0, 4));
        for (int c = 0; c < 26; c++) begin
            drive_cycle(1'b1, cur[7:0], cur[8], er, ea);
            tests_run++;
            if (ready !== er || align_active !== ea) begin
                tests_failed++;
                $display("FAIL align_cycle%0d: got ready %b align %b required %b %b", c, ready, align_active, er, ea);
            end
            if (ready === 1'b1) begin
                if (low_len > 0) begin
                    tests_run++;
                    if (low_len != AB) begin tests_failed++; $display("FAIL burst_len: got %0d required %0d", low_len, AB); end
                end
                low_len = 0;
                if (streak >= 0) streak++;
            end else begin
                if (streak > 0) begin
                    tests_run++;
                    if (streak != AP) begin tests_failed++; $display("FAIL accept_run: got %0d required %0d", streak, AP); end
                end
                streak = 0;
                low_len++;
            end
            if (er) cur = pick_byte($urandom_range(0, 4));
        end
    endtask

    task automatic test_disable();
        logic er, ea;
        for (int i = 0; i < AB && align_left != 0; i++) drive_cycle(1'b0, 8'h00, 1'b0, er, ea);
        @(negedge clk);
        enable = 1'b0; valid = 1'b1; data = 8'h4A; datak = 1'b0;
        exp_q.push_back(IDLE_TOK);
        #1;
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("FAIL disable_ready: got %b required 0", ready); end
        @(negedge clk);
        valid = 1'b0;
        exp_q.push_back(IDLE_TOK);
        #1;
        tests_run++;
        if (state_dbg !== 2'd0 || train_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL disable_off: got state %0d done %b required 0 0", state_dbg, train_done);
        end
        test_train();
        drive_cycle(1'b1, 8'hFF, 1'b0, er, ea);
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL reenable_ready: got %b required 1", ready); end
    endtask

    task automatic test_kcheck();
        logic er, ea;
        for (int i = 0; i < AB && align_left != 0; i++) drive_cycle(1'b0, 8'h00, 1'b0, er, ea);
        drive_cycle(1'b1, 8'hAB, 1'b1, er, ea);
        drive_cycle(1'b0, 8'h00, 1'b0, er, ea);
        tests_run++;
`ifdef ENC8B10B_SCHED_KCHECK_EN
        if (kerr !== 1'b1) begin tests_failed++; $display("FAIL kerr_pulse: got %b required 1", kerr); end
`else
        if (kerr !== 1'b0) begin tests_failed++; $display("FAIL kerr_off: got %b required 0", kerr); end
`endif
        drive_cycle(1'b0, 8'h00, 1'b0, er, ea);
        tests_run++;
        if (kerr !== 1'b0) begin tests_failed++; $display("FAIL kerr_width: got %b required 0", kerr); end
    endtask

    task automatic test_rst_mid();
        logic er, ea;
        drive_cycle(1'b1, 8'h4A, 1'b0, er, ea);
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1; valid = 1'b1; data = 8'hFF; datak = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (data10 !== 10'h283 || run_disp !== 1'b0 || ready !== 1'b0 || train_done !== 1'b0 ||
            align_active !== 1'b0 || kerr !== 1'b0 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: got data10 %h rd %b ready %b done %b align %b kerr %b state %0d required 283 0 0 0 0 0 0",
                     data10, run_disp, ready, train_done, align_active, kerr, state_dbg);
        end
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL sb_leftover: got %0d entries required 0", exp_q.size()); end
        rst = 1'b0; enable = 1'b0; valid = 1'b0;
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_train();
        test_data();
        test_align();
        test_disable();
        test_kcheck();
        test_rst_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
